// File: rtl/quad_encoder_decoder.sv
// quad_encoder_decoder: 2-FF synchronised, glitch-filtered X4 quadrature decoder with wrapping position count.
// Define QDEC_VELOCITY_EN to add the windowed, saturating velocity sampler.
module quad_encoder_decoder #(
   parameter int POS_W    = 16,
   parameter int FILT_LEN = 4,
   parameter int VEL_W    = 12,
   parameter int VEL_WIN  = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             clr_pos,
   output logic [POS_W-1:0] pos,
   output logic             dir,
   output logic             step,
   output logic             err,
   output logic [VEL_W-1:0] vel,
   output logic             vel_valid
);
   localparam int FCNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);

   // Channel vectors are packed as {A, B}
   logic [1:0]              sync1_q, sync1_d;
   logic [1:0]              sync2_q, sync2_d;
   logic [1:0]              filt_q, filt_d;
   logic [1:0]              prev_q, prev_d;
   logic [1:0][FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic [POS_W-1:0]        pos_q, pos_d;
   logic                    dir_q, dir_d;
   logic                    step_q, step_d;
   logic                    err_q, err_d;
   logic                    fwd, rev, illegal;

   always_comb begin
      sync1_d = {enc_a, enc_b};
      sync2_d = sync1_q;
      filt_d  = filt_q;
      fcnt_d  = fcnt_q;
      prev_d  = filt_q;
      // A channel must sit away from its filtered level FILT_LEN cycles running before it is accepted
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == filt_q[i]) begin
            fcnt_d[i] = '0;
         end else if (fcnt_q[i] == FCNT_LAST) begin
            filt_d[i] = sync2_q[i];
            fcnt_d[i] = '0;
         end else begin
            fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
         end
      end
   end

   always_comb begin
      fwd     = 1'b0;
      rev     = 1'b0;
      illegal = 1'b0;
      case ({prev_q, filt_q})
         4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd     = 1'b1;
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev     = 1'b1;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
         default: ;
      endcase

      step_d = fwd | rev;
      dir_d  = dir_q;
      pos_d  = pos_q;
      err_d  = err_q | illegal;
      if (fwd) begin
         dir_d = 1'b1;
         pos_d = pos_q + POS_W'(1);
      end else if (rev) begin
         dir_d = 1'b0;
         pos_d = pos_q - POS_W'(1);
      end
      // Clear wins over the count but the step strobe and direction still report the motion
      if (clr_pos) begin
         pos_d = '0;
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
         filt_q  <= 2'b00;
         prev_q  <= 2'b00;
         fcnt_q  <= '0;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         prev_q  <= prev_d;
         fcnt_q  <= fcnt_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         err_q   <= err_d;
      end
   end

   assign pos  = pos_q;
   assign dir  = dir_q;
   assign step = step_q;
   assign err  = err_q;

`ifdef QDEC_VELOCITY_EN
   localparam int WIN_W  = (VEL_WIN > 2) ? $clog2(VEL_WIN) : 1;
   localparam int ACC_W0 = $clog2(VEL_WIN + 1) + 1;
   localparam int ACC_W  = (ACC_W0 > VEL_W) ? ACC_W0 : VEL_W + 1;
   localparam logic signed [ACC_W-1:0] VEL_MAX = ACC_W'((1 << (VEL_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] VEL_MIN = ACC_W'(-(1 << (VEL_W - 1)));
   localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(VEL_WIN - 1);

   logic [WIN_W-1:0]        win_q, win_d;
   logic signed [ACC_W-1:0] acc_q, acc_d, step_inc;
   logic [VEL_W-1:0]        vel_q, vel_d;
   logic                    vel_valid_q, vel_valid_d;

   always_comb begin
      if (fwd)      step_inc = ACC_W'(1);
      else if (rev) step_inc = '1;
      else          step_inc = '0;

      win_d       = win_q + WIN_W'(1);
      acc_d       = acc_q + step_inc;
      vel_d       = vel_q;
      vel_valid_d = 1'b0;
      // Window boundary: publish the saturated sum; a step decoded now opens the next window
      if (win_q == WIN_LAST) begin
         win_d       = '0;
         acc_d       = step_inc;
         vel_valid_d = 1'b1;
         if (acc_q > VEL_MAX)      vel_d = VEL_MAX[VEL_W-1:0];
         else if (acc_q < VEL_MIN) vel_d = VEL_MIN[VEL_W-1:0];
         else                      vel_d = acc_q[VEL_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_q       <= '0;
         acc_q       <= '0;
         vel_q       <= '0;
         vel_valid_q <= 1'b0;
      end else begin
         win_q       <= win_d;
         acc_q       <= acc_d;
         vel_q       <= vel_d;
         vel_valid_q <= vel_valid_d;
      end
   end

   assign vel       = vel_q;
   assign vel_valid = vel_valid_q;
`else
   assign vel       = '0;
   assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// Bench for quad_encoder_decoder: directed and random quadrature motion against a gray-index position model.
// A second, 4-bit-position instance shares the pins so the signed wrap boundary is reached in a few steps.
module tb_quad_encoder_decoder;
   localparam int FL = 4;

   logic        clk = 1'b0;
   logic        rst, enc_a, enc_b, clr_pos;
   logic [15:0] pos;
   logic        dir, step, err, vel_valid;
   logic [11:0] vel;
   logic [3:0]  pos_w, vel_w;
   logic        dir_w, step_w, err_w, vel_valid_w;

   int total = 0;
   int bad   = 0;

   logic [15:0] m_pos;
   logic        m_dir, m_err, m_step, m_a, m_b;
   logic [1:0]  ring [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   always #5 clk = ~clk;

   quad_encoder_decoder #(.POS_W(16), .FILT_LEN(FL), .VEL_W(12), .VEL_WIN(1000)) dut (
      .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr_pos(clr_pos),
      .pos(pos), .dir(dir), .step(step), .err(err), .vel(vel), .vel_valid(vel_valid));

   quad_encoder_decoder #(.POS_W(4), .FILT_LEN(FL), .VEL_W(4), .VEL_WIN(1000)) dut_w (
      .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr_pos(clr_pos),
      .pos(pos_w), .dir(dir_w), .step(step_w), .err(err_w), .vel(vel_w), .vel_valid(vel_valid_w));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int idx(input logic a, input logic b);
      case ({a, b})
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Gray-ring distance: +1 forward, +3 reverse, +2 both pins moved
   task automatic model_step(input logic na, input logic nb);
      int d;
      d = (idx(na, nb) - idx(m_a, m_b) + 4) % 4;
      m_step = 1'b0;
      if (d == 1) begin
         m_pos = m_pos + 16'd1; m_dir = 1'b1; m_step = 1'b1;
      end else if (d == 3) begin
         m_pos = m_pos - 16'd1; m_dir = 1'b0; m_step = 1'b1;
      end else if (d == 2) begin
         m_err = 1'b1;
      end
      m_a = na;
      m_b = nb;
   endtask

   task automatic model_reset();
      m_pos = '0; m_dir = 1'b0; m_err = 1'b0; m_step = 1'b0; m_a = 1'b0; m_b = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".pos"},    pos,    m_pos);
      chk({tag, ".dir"},    dir,    m_dir);
      chk({tag, ".step"},   step,   m_step);
      chk({tag, ".err"},    err,    m_err);
      chk({tag, ".pos_w"},  pos_w,  m_pos[3:0]);
      chk({tag, ".dir_w"},  dir_w,  m_dir);
      chk({tag, ".step_w"}, step_w, m_step);
      chk({tag, ".err_w"},  err_w,  m_err);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".pos"},       pos,       0);
      chk({tag, ".dir"},       dir,       0);
      chk({tag, ".step"},      step,      0);
      chk({tag, ".err"},       err,       0);
      chk({tag, ".vel"},       vel,       0);
      chk({tag, ".vel_valid"}, vel_valid, 0);
      chk({tag, ".pos_w"},     pos_w,     0);
   endtask

   // Drive new pin levels and check the output lands exactly FILT_LEN+2 edges after first-FF capture
   task automatic move(input logic na, input logic nb, input bit clr_late, input string tag);
      enc_a = na;
      enc_b = nb;
      tick(FL + 2);
      chk({tag, ".early_pos"},  pos,  m_pos);
      chk({tag, ".early_step"}, step, 0);
      clr_pos = clr_late;
      tick(1);
      clr_pos = 1'b0;
      model_step(na, nb);
      if (clr_late) begin
         m_pos = '0;
         m_err = 1'b0;
      end
      check_all(tag);
      tick(1);
      chk({tag, ".step_end"}, step, 0);
   endtask

   task automatic go(input bit fw, input bit clr_late, input string tag);
      logic [1:0] nv;
      nv = ring[(idx(m_a, m_b) + (fw ? 1 : 3)) % 4];
      move(nv[1], nv[0], clr_late, tag);
   endtask

   task automatic clear(input string tag);
      clr_pos = 1'b1;
      tick(1);
      clr_pos = 1'b0;
      m_pos = '0;
      m_err = 1'b0;
      m_step = 1'b0;
      check_all(tag);
   endtask

   initial begin
      logic ga, orig;
      rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; clr_pos = 1'b0;
      model_reset();
      tick(4);
      chk_reset("reset");
      rst = 1'b0;
      tick(2);
      check_all("idle");

      // Eight forward edges, 20 cycles apart; the 4-bit copy crosses 7 -> 8 (max positive -> max negative)
      for (int i = 0; i < 8; i++) begin
         go(1'b1, 1'b0, "fwd8");
         tick(20 - (FL + 4));
      end
      chk("fwd8.final_pos", pos, 16'd8);
      chk("fwd8.dir", dir, 1);
      chk("wrap_w.min_neg", pos_w, 4'h8);

      clear("clr_a");
      for (int i = 0; i < 3; i++) go(1'b0, 1'b0, "rev3");
      chk("rev3.final_pos", pos, 16'hFFFD);
      chk("rev3.dir", dir, 0);
      clear("clr_b");

      // Pulse one tick short of the filter length is discarded
      orig = m_a;
      enc_a = ~orig;
      tick(FL - 1);
      enc_a = orig;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         chk("glitch.step", step, 0);
      end
      chk("glitch.pos", pos, m_pos);

      // Pulse exactly the filter length is accepted, and so is the return edge
      ga = ~orig;
      enc_a = ga;
      tick(FL);
      enc_a = orig;
      tick(2);
      chk("pulse4.early_step", step, 0);
      tick(1);
      model_step(ga, m_b);
      check_all("pulse4.out");
      tick(FL - 1);
      chk("pulse4.ret_early", step, 0);
      tick(1);
      model_step(orig, m_b);
      check_all("pulse4.back");
      tick(2);

      // Both pins in one cycle: sticky error with position held
      go(1'b1, 1'b0, "pre_ill");
      move(~m_a, ~m_b, 1'b0, "illegal");
      chk("illegal.err_set", err, 1);
      go(1'b1, 1'b0, "post_ill");
      go(1'b0, 1'b0, "post_ill2");
      chk("illegal.err_sticky", err, 1);
      clear("clr_err");

      // Clear coincident with a step: count zeroed, strobe and direction still reported
      go(1'b1, 1'b0, "pre_cs");
      go(1'b0, 1'b1, "clr_step");

      // Reset mid-motion, pins left at 10 so the first decode after release is 00 -> 10
      enc_a = ~m_a;
      tick(3);
      rst = 1'b1;
      enc_a = 1'b1;
      enc_b = 1'b0;
      tick(3);
      chk_reset("rst_mid");
      rst = 1'b0;
      model_reset();
      move(1'b1, 1'b0, 1'b0, "post_rst");

      for (int i = 0; i < 60; i++) begin
         int gap;
         if ($urandom_range(0, 9) == 0) clear("rnd_clr");
         go(1'($urandom_range(0, 1)), 1'b0, "rnd");
         gap = $urandom_range(0, 6);
         if (gap > 0) tick(gap);
      end

`ifdef QDEC_VELOCITY_EN
      rst = 1'b1;
      enc_a = 1'b0;
      enc_b = 1'b0;
      tick(2);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 10; i++) go(1'b1, 1'b0, "vel_fwd");
      for (int i = 0; i < 1500 && vel_valid !== 1'b1; i++) tick(1);
      chk("vel.valid_seen", vel_valid, 1);
      chk("vel.value", vel, 12'd10);
      chk("vel_w.saturated", vel_w, 4'd7);
      chk("vel_w.valid", vel_valid_w, 1);
      tick(1);
      chk("vel.valid_pulse", vel_valid, 0);
`else
      for (int i = 0; i < 20; i++) begin
         go(1'b1, 1'b0, "novel");
      end
      chk("novel.vel", vel, 0);
      chk("novel.vel_valid", vel_valid, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
